// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - function-select codes and sequencer state encoding shared with the ALU decoder
package alu_pkg;

    localparam logic [2:0] FS_ADD     = 3'b000;
    localparam logic [2:0] FS_SUB     = 3'b001;
    localparam logic [2:0] FS_SRA     = 3'b010;
    localparam logic [2:0] FS_SRL     = 3'b011;
    localparam logic [2:0] FS_SLL     = 3'b100;
    localparam logic [2:0] FS_AND     = 3'b101;
    localparam logic [2:0] FS_OR      = 3'b110;
    localparam logic [2:0] FS_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one request at a time onto the shared ALU, iterating the 1-bit shifter
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_fs,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SHW-1:0]   req_shamt,
    output logic [2:0]       alu_fs,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_err,
    output logic             busy
);

    state_t           state, state_n;
    logic [2:0]       fs_q, fs_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic [SHW-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0] y_q, y_n;
    logic             err_q, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fs_q  <= FS_ADD;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            fs_q  <= fs_n;
            a_q   <= a_n;
            b_q   <= b_n;
            acc_q <= acc_n;
            cnt_q <= cnt_n;
            y_q   <= y_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        fs_n      = fs_q;
        a_n       = a_q;
        b_n       = b_q;
        acc_n     = acc_q;
        cnt_n     = cnt_q;
        y_n       = y_q;
        err_n     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_fs    = FS_ADD;
        alu_a     = '0;
        alu_b     = '0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    fs_n = req_fs;
                    a_n  = req_a;
                    b_n  = req_b;
                    case (req_fs)
                        FS_ADD, FS_SUB, FS_AND, FS_OR: state_n = EXEC;
                        FS_SRA, FS_SRL, FS_SLL: begin
                            if (req_shamt != '0) begin
                                acc_n   = req_a;
                                cnt_n   = req_shamt;
                                state_n = SHIFT;
                            end else begin
                                y_n     = req_a;
                                err_n   = 1'b0;
                                state_n = DONE;
                            end
                        end
                        default: begin
                            y_n     = '0;
                            err_n   = 1'b1;
                            state_n = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                alu_fs  = fs_q;
                alu_a   = a_q;
                alu_b   = b_q;
                y_n     = alu_y;
                err_n   = 1'b0;
                state_n = DONE;
            end
            SHIFT: begin
                // The ALU shifts one position per cycle; its result is fed back as the next operand.
                alu_fs = fs_q;
                alu_a  = acc_q;
                alu_b  = {{(WIDTH-1){1'b0}}, 1'b1};
                acc_n  = alu_y;
                cnt_n  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    y_n     = alu_y;
                    err_n   = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rsp_y   = y_q;
    assign rsp_err = err_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench with an ALU model and a behavioural reference for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_fs = 3'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_shamt = '0;
    logic [2:0]  alu_fs;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_y;
    logic        rsp_err;
    logic        busy;

    alu_op_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_fs(req_fs),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared single-cycle ALU: shifts move one position per evaluation.
    always_comb begin
        case (alu_fs)
            3'b000:  alu_y = alu_a + alu_b;
            3'b001:  alu_y = alu_a - alu_b;
            3'b010:  alu_y = {alu_a[31], alu_a[31:1]};
            3'b011:  alu_y = {1'b0, alu_a[31:1]};
            3'b100:  alu_y = {alu_a[30:0], 1'b0};
            3'b101:  alu_y = alu_a & alu_b;
            3'b110:  alu_y = alu_a | alu_b;
            default: alu_y = '0;
        endcase
    end

    typedef struct {
        logic [31:0] y;
        logic        err;
        int          lat;
        int          c0;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   rr_mode    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] fs, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t e;
        e.err = 1'b0;
        e.c0  = 0;
        e.lat = 2;
        case (fs)
            3'd0: e.y = a + b;
            3'd1: e.y = a - b;
            3'd2: e.y = 32'($signed(a) >>> sh);
            3'd3: e.y = a >> sh;
            3'd4: e.y = a << sh;
            3'd5: e.y = a & b;
            3'd6: e.y = a | b;
            default: begin
                e.y   = '0;
                e.err = 1'b1;
            end
        endcase
        if (fs == 3'd2 || fs == 3'd3 || fs == 3'd4) e.lat = (sh == 0) ? 1 : int'(sh) + 1;
        if (fs == 3'd7) e.lat = 1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called and returns on a falling edge; waited reports how many cycles req_ready was low.
    task automatic issue(input logic [2:0] fs, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int waited);
        exp_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_fs    = fs;
        req_a     = a;
        req_b     = b;
        req_shamt = sh;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e    = model(fs, a, b, sh);
        e.c0 = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_fs    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        req_shamt = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       rsp_ready = 1'($urandom_range(0, 1));
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        logic        prev_valid = 1'b0;
        logic [31:0] prev_y     = '0;
        logic        prev_err   = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (rsp_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_response", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("rsp_y", rsp_y, e.y);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("latency", 32'(cyc - e.c0 + 1), 32'(e.lat));
                    end
                end else if (rsp_valid && prev_valid) begin
                    check("rsp_y_stable", rsp_y, prev_y);
                    check("rsp_err_stable", 32'(rsp_err), 32'(prev_err));
                end
                if (!busy || rsp_valid)
                    check("alu_quiet", {alu_fs, alu_a[0], alu_b[0]} | 32'(alu_a != 0) | 32'(alu_b != 0), 32'd0);
                prev_valid = rsp_valid;
                prev_y     = rsp_y;
                prev_err   = rsp_err;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int w;
        int n;
        logic [2:0] fs;
        logic [4:0] sh;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_y", rsp_y, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_alu", {29'd0, alu_fs} | alu_a | alu_b, 32'd0);

        rr_mode = 0;
        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd0, w);
        drain();
        issue(3'd1, 32'd5, 32'd7, 5'd0, w);
        drain();
        issue(3'd2, 32'h8000_0000, 32'h0, 5'd4, w);
        drain();
        issue(3'd3, 32'h8000_0000, 32'h0, 5'd4, w);
        drain();
        issue(3'd4, 32'd1, 32'h0, 5'd31, w);
        drain();
        issue(3'd3, 32'h0000_1234, 32'hDEAD, 5'd0, w);
        drain();
        issue(3'd7, 32'hABCD_0123, 32'h55, 5'd3, w);
        drain();

        // Backpressure: response must stay put while the consumer stalls.
        rr_mode = 1;
        issue(3'd5, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, w);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            check("bp_req_ready_low", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        rr_mode   = 2;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after_handshake", 32'(req_ready), 32'd1);
        issue(3'd6, 32'h1200_0034, 32'h0056_0000, 5'd0, w);
        check("bp_back_to_back_wait", 32'(w), 32'd0);
        drain();

        // Abort a 10-step shift partway through.
        rr_mode = 0;
        issue(3'd4, 32'd1, 32'd0, 5'd10, w);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (15) @(negedge clk);
        issue(3'd0, 32'h1234_5678, 32'h1111_1111, 5'd0, w);
        drain();

        for (int i = 0; i < 40; i++) begin
            fs = 3'($urandom);
            sh = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            rr_mode = (i % 5 == 4) ? 2 : 0;
            issue(fs, $urandom, $urandom, sh, w);
            if (i % 3 == 0) drain();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequences operations onto the shared single-cycle ALU (adder/subtractor, 1-bit-per-cycle shifter, AND/OR logic unit). It accepts one operation request at a time over a valid/ready handshake and drives the ALU function select and operands. Multi-bit shifts are built by iterating the 1-position shifter, with the result fed back each cycle. The result is returned over a second valid/ready handshake. The block sits between the instruction issue logic and the ALU datapath.

## Interface
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width; equals clog2(WIDTH)
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_fs  in  3  function select: ADD=000, SUB=001, SRA=010, SRL=011, SLL=100, AND=101, OR=110; 111 is illegal
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B; ignored for shifts
- req_shamt  in  SHW  shift amount; ignored for non-shifts
- alu_fs  out  3  FS to ALU control decoder
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_y  in  WIDTH  ALU result, combinational from alu_fs/alu_a/alu_b
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_y  out  WIDTH  result
- rsp_err  out  1  request had illegal FS
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, SHIFT, DONE.
- req_ready = (state==IDLE). A request is accepted on an edge where req_valid && req_ready. On acceptance, fs, a, b and shamt are latched into internal registers.
- Transitions out of IDLE on accept:
  - ADD/SUB/AND/OR → EXEC.
  - Shift with shamt≥1 → SHIFT; acc←a, cnt←shamt.
  - Shift with shamt=0 → DONE; rsp_y←a, rsp_err←0.
  - FS=111 → DONE; rsp_y←0, rsp_err←1.
- EXEC (one cycle): alu_fs=fs, alu_a=a, alu_b=b. At the edge, rsp_y←alu_y, rsp_err←0, state→DONE.
- SHIFT (one cycle per iteration): alu_fs=fs, alu_a=acc, alu_b=1. At each edge, acc←alu_y and cnt←cnt−1. When cnt==1 at the edge, also rsp_y←alu_y and state→DONE.
- In IDLE and DONE: alu_fs=000, alu_a=0, alu_b=0. This quiets the ALU.
- DONE: rsp_valid=1, and rsp_y/rsp_err are held stable. On rsp_valid && rsp_ready, state→IDLE.
- rsp_valid is never deasserted before the response handshake. req_* are don't-care outside IDLE.
- Arithmetic wraps modulo 2^WIDTH; no carry or overflow is reported.
- SRA replicates the MSB on each iteration; SRL and SLL fill with 0. This is the ALU's per-step behaviour.
- rst (any state, including mid-shift): state→IDLE and any in-flight op is dropped with no response. Outputs:
  - rsp_valid=0, rsp_y=0, rsp_err=0, busy=0
  - alu_fs=000, alu_a=0, alu_b=0
  - req_ready=1 in the cycle after reset, if rst is low by then.

## Timing
- Latency is counted from the accept edge to the first cycle with rsp_valid=1.
  - ADD/SUB/AND/OR: 2 cycles.
  - Shift by k≥1: k+1 cycles.
  - Shift by 0 or illegal FS: 1 cycle.
- The response handshake edge returns the block to IDLE, and req_ready is high in the next cycle. Minimum request spacing is therefore latency+1 cycles; there is no overlap between requests.
- If rsp_ready is already high when rsp_valid rises, the handshake completes in that same cycle.
- alu_fs/alu_a/alu_b depend only on registered state. The ALU path from alu_* to alu_y must fit in one cycle.

## Structure
- Shared package alu_pkg holds:
  - the FS code localparams (FS_ADD … FS_OR, FS_ILLEGAL=3'b111);
  - the state encoding localparams (IDLE, EXEC, SHIFT, DONE).
- The ALU decoder uses the same FS code localparams from this package.
- No sub-module: the counter and accumulator are inline. The ALU and its control decoder are instantiated beside this block at the datapath top level.

## Test plan
- Reset: hold rst for 2 cycles, then release → all outputs 0, req_ready=1, busy=0.
- ADD: a=0xFFFFFFFF, b=2 → rsp_y=0x00000001, rsp_err=0, rsp_valid 2 cycles after accept. SUB: a=5, b=7 → 0xFFFFFFFE.
- SRA: a=0x80000000, shamt=4 → rsp_y=0xF8000000 after 5 cycles. SRL with same inputs → 0x08000000. SLL: a=1, shamt=31 → 0x80000000 after 32 cycles.
- Edge cases: shift with shamt=0 and a=0x1234 → rsp_y=0x1234 after 1 cycle. FS=111 → rsp_err=1, rsp_y=0 after 1 cycle.
- Backpressure: AND a=0xF0F0, b=0xFF00, with rsp_ready low for 5 cycles → rsp_valid and rsp_y=0xF000 stay stable and req_ready stays 0. Then raise rsp_ready → IDLE next cycle, and a back-to-back request is accepted.
- Abort: assert rst during cycle 3 of a 10-step shift → no response is produced, the block returns to IDLE, and the next ADD completes correctly.
